// File: rtl/pic_sfr_pkg.sv
// Shared SFR-side definitions for the TMR0/WDT/prescaler controller:
// bus addresses, OPTION_REG bit positions and the controller state types.
package pic_sfr_pkg;

    typedef logic [7:0] sfr_byte_t;

    localparam sfr_byte_t SFR_TMR0_ADDR    = 8'h01;
    localparam sfr_byte_t SFR_OPTION_ADDR  = 8'h81;
    localparam int        TMR0_INHIBIT_CYC = 8;

    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;

    localparam sfr_byte_t OPTION_RST = 8'hFF;

    typedef enum logic [1:0] {IDLE, CLR1, APPLY, SETTLE} reasgn_state_t;
    typedef enum logic       {RUN, SLEEP}                pwr_state_t;

    // A write that flips PSA moves the prescaler between TMR0 and WDT.
    function automatic logic psa_changes(sfr_byte_t cur, sfr_byte_t nxt);
        return cur[OPT_PSA] != nxt[OPT_PSA];
    endfunction

endpackage

// File: rtl/tmr0wdt_ctrl_if.sv
// SFR bus between the core (master) and the TMR0/WDT controller (slave).
interface tmr0wdt_ctrl_if;
    import pic_sfr_pkg::*;

    logic      sfr_wr_en;
    sfr_byte_t sfr_addr;
    sfr_byte_t sfr_wr_data;
    sfr_byte_t sfr_rd_data;

    modport master (output sfr_wr_en, sfr_addr, sfr_wr_data, input sfr_rd_data);
    modport slave  (input sfr_wr_en, sfr_addr, sfr_wr_data, output sfr_rd_data);
endinterface

// File: rtl/tmr0wdt_ctrl_inhibit_cnt.sv
// Loadable down-counter; active stays high for LOAD_VAL clks after each load.
module tmr0_inhibit_cnt #(
    parameter int LOAD_VAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);
    localparam int W = $clog2(LOAD_VAL + 1);
    localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign active = (cnt != '0);
endmodule

// File: rtl/tmr0wdt_ctrl.sv
// TMR0/WDT/prescaler sequencing: OPTION_REG and TO/PD ownership, TMR0 loads,
// safe prescaler reassignment, and CLRWDT/SLEEP/WDT strobe generation.
//
// state  | meaning
// IDLE   | no reassignment in progress, OPTION writes apply directly
// CLR1   | old PSA/PS held, prescaler and WDT cleared, TMR0 held
// APPLY  | new OPTION loaded, clears repeated, TMR0 held
// SETTLE | TMR0 held one more clk, WDT reset still masked
//
// pwr    | meaning
// RUN    | core executing
// SLEEP  | waiting for interrupt or WDT wake
module tmr0wdt_ctrl
    import pic_sfr_pkg::*;
#(
    parameter sfr_byte_t TMR0_ADDR   = SFR_TMR0_ADDR,
    parameter sfr_byte_t OPTION_ADDR = SFR_OPTION_ADDR,
    parameter int        INHIBIT_CYC = TMR0_INHIBIT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          por,
    tmr0wdt_ctrl_if.slave sfr,
    input  logic          clrwdt_exec,
    input  logic          sleep_exec,
    input  logic          irq_wake,
    input  logic          wdt_en,
    input  logic [7:0]    tmr0_val,
    input  logic          tmr0if_set_en,
    input  logic          wdt_timeout,
    output logic          t0cs,
    output logic          t0se,
    output logic          psa,
    output logic [2:0]    ps,
    output logic          tmr0_wr_en,
    output logic [7:0]    tmr0_wr_data,
    output logic          tmr0_cnt_inhibit,
    output logic          pres_clr,
    output logic          wdt_clr,
    output logic          t0if_set,
    output logic          wdt_reset_req,
    output logic          wake,
    output logic          to_n,
    output logic          pd_n,
    output logic          busy
);
    reasgn_state_t state, state_nxt;
    pwr_state_t    pwr_state, pwr_nxt;
    sfr_byte_t     option_reg, opt_nxt;
    sfr_byte_t     stage_reg, stage_nxt;
    sfr_byte_t     pend_data, pend_data_nxt, opt_req;
    logic          pend_valid, pend_valid_nxt;
    logic          to_nxt, pd_nxt;
    logic          pres_nxt, wdt_clr_nxt, rst_req_nxt, wake_nxt;
    logic          tmo_hit, pwr_evt, sfr_ok, wr_tmr0, wr_opt, inh_active;

    always_comb begin
        state_nxt      = state;
        pwr_nxt        = pwr_state;
        opt_nxt        = option_reg;
        stage_nxt      = stage_reg;
        pend_valid_nxt = pend_valid;
        pend_data_nxt  = pend_data;
        opt_req        = pend_data;
        to_nxt         = to_n;
        pd_nxt         = pd_n;
        pres_nxt       = 1'b0;
        wdt_clr_nxt    = 1'b0;
        rst_req_nxt    = 1'b0;
        wake_nxt       = 1'b0;

        // An accepted timeout pre-empts CLRWDT/SLEEP, which pre-empt SFR writes.
        tmo_hit = wdt_timeout && wdt_en && (state == IDLE);
        pwr_evt = !tmo_hit && (pwr_state == RUN) && (clrwdt_exec || sleep_exec);
        sfr_ok  = sfr.sfr_wr_en && !tmo_hit && !pwr_evt;
        wr_tmr0 = sfr_ok && (sfr.sfr_addr == TMR0_ADDR);
        wr_opt  = sfr_ok && (sfr.sfr_addr == OPTION_ADDR);

        case (state)
            IDLE: begin
                if (wr_opt || pend_valid) begin
                    opt_req        = wr_opt ? sfr.sfr_wr_data : pend_data;
                    pend_valid_nxt = 1'b0;
                    if (psa_changes(option_reg, opt_req)) begin
                        stage_nxt   = opt_req;
                        state_nxt   = CLR1;
                        pres_nxt    = 1'b1;
                        wdt_clr_nxt = 1'b1;
                    end else begin
                        opt_nxt = opt_req;
                    end
                end
            end
            CLR1: begin
                state_nxt   = APPLY;
                opt_nxt     = stage_reg;
                pres_nxt    = 1'b1;
                wdt_clr_nxt = 1'b1;
            end
            APPLY:   state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE && wr_opt) begin
            pend_valid_nxt = 1'b1;
            pend_data_nxt  = sfr.sfr_wr_data;
        end

        if (wr_tmr0 && !option_reg[OPT_PSA]) begin
            pres_nxt = 1'b1;
        end

        if (tmo_hit) begin
            to_nxt = 1'b0;
            if (pwr_state == RUN) begin
                rst_req_nxt = 1'b1;
            end else begin
                wake_nxt = 1'b1;
                pwr_nxt  = RUN;
            end
        end else if (pwr_evt) begin
            wdt_clr_nxt = 1'b1;
            if (option_reg[OPT_PSA]) begin
                pres_nxt = 1'b1;
            end
            to_nxt = 1'b1;
            pd_nxt = !sleep_exec;
            if (sleep_exec) begin
                // Interrupt already pending: SLEEP behaves as an immediate wake.
                if (irq_wake) begin
                    wake_nxt = 1'b1;
                end else begin
                    pwr_nxt = SLEEP;
                end
            end
        end else if (pwr_state == SLEEP && irq_wake) begin
            wake_nxt = 1'b1;
            pwr_nxt  = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pwr_state     <= RUN;
            option_reg    <= OPTION_RST;
            stage_reg     <= OPTION_RST;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            tmr0_wr_en    <= 1'b0;
            tmr0_wr_data  <= '0;
            pres_clr      <= 1'b0;
            wdt_clr       <= 1'b0;
            t0if_set      <= 1'b0;
            wdt_reset_req <= 1'b0;
            wake          <= 1'b0;
            if (por) begin
                to_n <= 1'b1;
                pd_n <= 1'b1;
            end
        end else begin
            state         <= state_nxt;
            pwr_state     <= pwr_nxt;
            option_reg    <= opt_nxt;
            stage_reg     <= stage_nxt;
            pend_valid    <= pend_valid_nxt;
            pend_data     <= pend_data_nxt;
            tmr0_wr_en    <= wr_tmr0;
            if (wr_tmr0) begin
                tmr0_wr_data <= sfr.sfr_wr_data;
            end
            pres_clr      <= pres_nxt;
            wdt_clr       <= wdt_clr_nxt;
            t0if_set      <= tmr0if_set_en && !wr_tmr0;
            wdt_reset_req <= rst_req_nxt;
            wake          <= wake_nxt;
            to_n          <= to_nxt;
            pd_n          <= pd_nxt;
        end
    end

    tmr0_inhibit_cnt #(
        .LOAD_VAL (INHIBIT_CYC)
    ) u_inhibit (
        .clk    (clk),
        .rst    (rst),
        .load   (wr_tmr0),
        .active (inh_active)
    );

    assign busy             = (state != IDLE);
    assign tmr0_cnt_inhibit = inh_active || busy;

    assign t0cs = option_reg[OPT_T0CS];
    assign t0se = option_reg[OPT_T0SE];
    assign psa  = option_reg[OPT_PSA];
    assign ps   = option_reg[OPT_PS_MSB:0];

    assign sfr.sfr_rd_data = (sfr.sfr_addr == TMR0_ADDR)   ? tmr0_val   :
                             (sfr.sfr_addr == OPTION_ADDR) ? option_reg : 8'h00;
endmodule
